// File: rtl/systolic_array_controller.sv
// Sequencer for an N x N weight-stationary MAC grid: loads weight rows, skews input
// vectors into the left column and deskews bottom-row sums into aligned result vectors.
module systolic_array_controller #(
    parameter int unsigned ARRAY_SIZE       = 4,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned WEIGHT_BITS      = 8,
    parameter int unsigned ACCUMULATOR_BITS = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   load_start,
    output logic                                   busy,
    output logic                                   done,
    input  logic                                   w_valid,
    output logic                                   w_ready,
    input  logic [ARRAY_SIZE*WEIGHT_BITS-1:0]      w_row,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ARRAY_SIZE*DATA_BITS-1:0]        in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ARRAY_SIZE*ACCUMULATOR_BITS-1:0] out_data,
    output logic                                   out_last,
    output logic [ARRAY_SIZE*WEIGHT_BITS-1:0]      array_weight,
    output logic [ARRAY_SIZE-1:0]                  array_weight_set,
    output logic                                   array_stall,
    output logic [ARRAY_SIZE*DATA_BITS-1:0]        array_data,
    input  logic [ARRAY_SIZE*ACCUMULATOR_BITS-1:0] array_acc
);
    localparam int unsigned N     = ARRAY_SIZE;
    localparam int unsigned LAT   = 2 * N;
    localparam int unsigned ROW_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(LAT + 2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT-1:0]   vld_q, last_q;
    logic             adv, accept, take;

    // The whole pipeline (skew, array, deskew, valid/last) moves only when the output can drain.
    assign out_valid   = vld_q[LAT-1];
    assign out_last    = last_q[LAT-1];
    assign adv         = !out_valid || out_ready;
    assign array_stall = !adv;
    assign accept      = in_valid && in_ready;
    assign take        = out_valid && out_ready;

    always_comb begin
        state_d          = state_q;
        row_d            = row_q;
        busy             = 1'b1;
        done             = 1'b0;
        w_ready          = 1'b0;
        in_ready         = 1'b0;
        array_weight     = '0;
        array_weight_set = '0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (load_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    array_weight     = w_row;
                    array_weight_set = N'(1) << row_q;
                    if (row_q == ROW_W'(N - 1)) begin
                        row_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                in_ready = adv;
                if (in_valid && adv && in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !take)      cnt_d = cnt_q + CNT_W'(1);
        else if (!accept && take) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            if (adv) begin
                vld_q  <= {vld_q[LAT-2:0], accept};
                last_q <= {last_q[LAT-2:0], accept && in_last};
            end
        end
    end

    // Row i sees its element after i+1 advancing steps; bubbles inject zeros.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_BITS-1:0] sk_q [i+1];
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) sk_q[s] <= '0;
            end else if (adv) begin
                sk_q[0] <= accept ? in_data[i*DATA_BITS +: DATA_BITS] : '0;
                for (int s = 1; s <= i; s++) sk_q[s] <= sk_q[s-1];
            end
        end
        assign array_data[i*DATA_BITS +: DATA_BITS] = sk_q[i];
    end

    // Column j leaves the bottom row j steps after column 0, so it is delayed N-1-j steps.
    for (genvar j = 0; j < N; j++) begin : g_deskew
        localparam int unsigned D = N - 1 - j;
        logic [ACCUMULATOR_BITS-1:0] col;
        if (D == 0) begin : g_pass
            assign col = array_acc[j*ACCUMULATOR_BITS +: ACCUMULATOR_BITS];
        end else begin : g_dly
            logic [ACCUMULATOR_BITS-1:0] dk_q [D];
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int s = 0; s < D; s++) dk_q[s] <= '0;
                end else if (adv) begin
                    dk_q[0] <= array_acc[j*ACCUMULATOR_BITS +: ACCUMULATOR_BITS];
                    for (int s = 1; s < D; s++) dk_q[s] <= dk_q[s-1];
                end
            end
            assign col = dk_q[D-1];
        end
        assign out_data[j*ACCUMULATOR_BITS +: ACCUMULATOR_BITS] = out_valid ? col : '0;
    end

endmodule

// File: tb/tb_systolic_array_controller.sv
// Directed bench for systolic_array_controller (N=2) with a behavioural 2x2 weight-stationary MAC grid.
module tb_systolic_array_controller;
    localparam int unsigned N   = 2;
    localparam int unsigned DB  = 8;
    localparam int unsigned WB  = 8;
    localparam int unsigned AB  = 16;
    localparam int unsigned LAT = 2 * N;

    logic            clock = 1'b0;
    logic            reset, load_start, busy, done;
    logic            w_valid, w_ready;
    logic [N*WB-1:0] w_row;
    logic            in_valid, in_ready, in_last;
    logic [N*DB-1:0] in_data;
    logic            out_valid, out_ready, out_last;
    logic [N*AB-1:0] out_data;
    logic [N*WB-1:0] array_weight;
    logic [N-1:0]    array_weight_set;
    logic            array_stall;
    logic [N*DB-1:0] array_data;
    logic [N*AB-1:0] array_acc;

    systolic_array_controller #(
        .ARRAY_SIZE(N), .DATA_BITS(DB), .WEIGHT_BITS(WB), .ACCUMULATOR_BITS(AB)
    ) dut (
        .clock(clock), .reset(reset), .load_start(load_start), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .array_weight(array_weight), .array_weight_set(array_weight_set),
        .array_stall(array_stall), .array_data(array_data), .array_acc(array_acc)
    );

    always #5 clock = ~clock;

    // Behavioural MAC grid: data moves right, partial sums move down, both registered per cell.
    logic [WB-1:0] wgt  [N][N];
    logic [DB-1:0] a_q  [N][N];
    logic [AB-1:0] p_q  [N][N];
    logic [DB-1:0] a_in [N][N];
    logic [AB-1:0] p_in [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = array_data[i*DB +: DB];
            for (int j = 1; j < N; j++) a_in[i][j] = a_q[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            p_in[0][j] = '0;
            for (int i = 1; i < N; i++) p_in[i][j] = p_q[i-1][j];
            array_acc[j*AB +: AB] = p_q[N-1][j];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    wgt[i][j] <= '0;
                    a_q[i][j] <= '0;
                    p_q[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                if (array_weight_set[i])
                    for (int j = 0; j < N; j++) wgt[i][j] <= array_weight[j*WB +: WB];
            if (!array_stall)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        a_q[i][j] <= a_in[i][j];
                        p_q[i][j] <= p_in[i][j] + AB'(a_in[i][j]) * AB'(wgt[i][j]);
                    end
        end
    end

    typedef struct {
        logic [DB-1:0] d0, d1;
        logic [AB-1:0] e0, e1;
        logic          last;
    } vec_t;
    vec_t tbl [7];

    int checks = 0, errors = 0, cyc = 0, rcyc = 0, rdy_mode = 0;
    int done_cnt = 0, done_cyc = 0;
    logic [N*AB-1:0] got_d [$];
    logic            got_l [$];
    int              got_c [$];
    int              acc_c [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Output-ready pattern: 0 = always ready, 1 = repeating 1,0,0,1.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : ((rcyc % 4 == 0) || (rcyc % 4 == 3));
            rcyc++;
        end
    end

    // Monitor: stall rule, output hold under backpressure, and handshake logging.
    initial begin
        logic            prev_hold, prev_l, prev_rst;
        logic [N*AB-1:0] prev_d;
        prev_hold = 1'b0; prev_l = 1'b0; prev_rst = 1'b1; prev_d = '0;
        forever begin
            @(negedge clock);
            cyc++;
            chk("array_stall", 64'(array_stall), 64'(out_valid && !out_ready));
            if (prev_hold && !prev_rst) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_data", 64'(out_data), 64'(prev_d));
                chk("hold_last", 64'(out_last), 64'(prev_l));
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_l    = out_last;
            prev_rst  = reset;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                got_c.push_back(cyc);
            end
            if (in_valid && in_ready) acc_c.push_back(cyc);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_logs();
        got_d.delete(); got_l.delete(); got_c.delete(); acc_c.delete();
    endtask

    // Loads W0=[a,b], W1=[c,d] starting from IDLE.
    task automatic load(input logic [7:0] a, b, c, d);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        w_valid = 1'b1;
        w_row   = {b, a};
        @(negedge clock);
        chk("load_busy", 64'(busy), 64'(1));
        chk("load_w_ready", 64'(w_ready), 64'(1));
        chk("load_wset0", 64'(array_weight_set), 64'(2'b01));
        chk("load_wrow0", 64'(array_weight), 64'({b, a}));
        step();
        w_row = {d, c};
        @(negedge clock);
        chk("load_wset1", 64'(array_weight_set), 64'(2'b10));
        chk("load_wrow1", 64'(array_weight), 64'({d, c}));
        step();
        w_valid = 1'b0;
        w_row   = '0;
    endtask

    task automatic send_vec(input logic [7:0] a, b, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = {b, a};
        in_last  = last;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clock);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        chk("in_accept", 64'(ok), 64'(1));
    endtask

    task automatic send_tbl(input int first, input int count, input int gap);
        for (int k = 0; k < count; k++) begin
            send_vec(tbl[first+k].d0, tbl[first+k].d1, tbl[first+k].last);
            repeat (gap) step();
        end
    endtask

    task automatic wait_done(input int base);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            step();
            seen = (done_cnt != base);
        end
        chk("done_seen", 64'(seen), 64'(1));
        @(negedge clock);
        chk("idle_after_done", 64'(busy), 64'(0));
    endtask

    task automatic check_batch(input int first, input int count, input bit lat);
        chk("n_out", 64'(got_d.size()), 64'(count));
        for (int k = 0; k < count; k++) begin
            if (k < got_d.size()) begin
                chk($sformatf("data%0d", first + k), 64'(got_d[k]),
                    64'({tbl[first+k].e1, tbl[first+k].e0}));
                chk($sformatf("last%0d", first + k), 64'(got_l[k]), 64'(tbl[first+k].last));
                if (lat && k < acc_c.size())
                    chk($sformatf("latency%0d", first + k), 64'(got_c[k] - acc_c[k]), 64'(LAT));
            end
        end
    endtask

    initial begin
        int base;
        // W0=[1,2], W1=[3,4]: out = [d0*1 + d1*3, d0*2 + d1*4]
        tbl[0] = '{d0: 8'd0,   d1: 8'd1,   e0: 16'd3,     e1: 16'd4,     last: 1'b0};
        tbl[1] = '{d0: 8'd1,   d1: 8'd2,   e0: 16'd7,     e1: 16'd10,    last: 1'b0};
        tbl[2] = '{d0: 8'd2,   d1: 8'd3,   e0: 16'd11,    e1: 16'd16,    last: 1'b0};
        tbl[3] = '{d0: 8'd3,   d1: 8'd4,   e0: 16'd15,    e1: 16'd22,    last: 1'b0};
        tbl[4] = '{d0: 8'd4,   d1: 8'd5,   e0: 16'd19,    e1: 16'd28,    last: 1'b0};
        tbl[5] = '{d0: 8'd5,   d1: 8'd6,   e0: 16'd23,    e1: 16'd34,    last: 1'b1};
        // All weights 255: 2*255*255 = 130050 wraps to 64514
        tbl[6] = '{d0: 8'd255, d1: 8'd255, e0: 16'd64514, e1: 16'd64514, last: 1'b1};

        reset = 1'b1; load_start = 1'b0; w_valid = 1'b0; w_row = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) step();
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_w_ready", 64'(w_ready), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_wset", 64'(array_weight_set), 64'(0));
        chk("rst_array_data", 64'(array_data), 64'(0));
        step();
        reset = 1'b0;

        // IDLE ignores w_valid and in_valid
        clear_logs();
        w_valid = 1'b1; w_row = 16'hFFFF; in_valid = 1'b1; in_data = 16'h0909;
        @(negedge clock);
        chk("idle_w_ready", 64'(w_ready), 64'(0));
        chk("idle_wset", 64'(array_weight_set), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(0));
        step();
        w_valid = 1'b0; w_row = '0; in_valid = 1'b0; in_data = '0;
        repeat (6) step();
        chk("idle_no_out", 64'(got_d.size()), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));

        // Single vector with in_last
        load(8'd1, 8'd2, 8'd3, 8'd4);
        clear_logs();
        base = done_cnt;
        send_vec(tbl[5].d0, tbl[5].d1, 1'b1);
        wait_done(base);
        check_batch(5, 1, 1'b1);
        if (got_c.size() > 0) chk("done_after_last", 64'(done_cyc - got_c[0]), 64'(1));
        repeat (3) step();
        chk("single_done_pulse", 64'(done_cnt - base), 64'(1));

        // Back-to-back stream, always ready
        load(8'd1, 8'd2, 8'd3, 8'd4);
        clear_logs();
        base = done_cnt;
        send_tbl(0, 6, 0);
        wait_done(base);
        check_batch(0, 6, 1'b1);
        for (int k = 1; k < 6; k++)
            if (k < acc_c.size()) chk($sformatf("b2b_accept%0d", k), 64'(acc_c[k] - acc_c[0]), 64'(k));

        // Backpressure: ready 1,0,0,1 repeating
        rdy_mode = 1;
        load(8'd1, 8'd2, 8'd3, 8'd4);
        clear_logs();
        base = done_cnt;
        send_tbl(0, 6, 0);
        wait_done(base);
        check_batch(0, 6, 1'b0);
        rdy_mode = 0;
        step();

        // Overflow wrap
        load(8'd255, 8'd255, 8'd255, 8'd255);
        clear_logs();
        base = done_cnt;
        send_tbl(6, 1, 0);
        wait_done(base);
        check_batch(6, 1, 1'b1);

        // Sparse input: three idle cycles between vectors
        load(8'd1, 8'd2, 8'd3, 8'd4);
        clear_logs();
        base = done_cnt;
        send_tbl(0, 6, 3);
        wait_done(base);
        check_batch(0, 6, 1'b1);

        // Reset after one weight row
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        w_valid = 1'b1; w_row = {8'd9, 8'd9};
        step();
        w_valid = 1'b0; w_row = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rl_busy", 64'(busy), 64'(0));
        chk("rl_w_ready", 64'(w_ready), 64'(0));
        chk("rl_wset", 64'(array_weight_set), 64'(0));

        // Reset with two vectors in flight
        load(8'd1, 8'd2, 8'd3, 8'd4);
        clear_logs();
        base = done_cnt;
        send_vec(8'd1, 8'd2, 1'b0);
        send_vec(8'd3, 8'd4, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rc_busy", 64'(busy), 64'(0));
        chk("rc_out_valid", 64'(out_valid), 64'(0));
        chk("rc_in_ready", 64'(in_ready), 64'(0));
        chk("rc_out_data", 64'(out_data), 64'(0));
        chk("rc_array_data", 64'(array_data), 64'(0));
        repeat (12) step();
        chk("rc_no_out", 64'(got_d.size()), 64'(0));
        chk("rc_no_done", 64'(done_cnt - base), 64'(0));

        // Full reload after reset
        load(8'd1, 8'd2, 8'd3, 8'd4);
        clear_logs();
        base = done_cnt;
        send_tbl(5, 1, 0);
        wait_done(base);
        check_batch(5, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
